// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: asserts an open-drain bus error when a CPU bus cycle runs
// TIMEOUT clocks without DTACK, and keeps a sticky fault flag plus a saturating fault count.
module bus_watchdog #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 127,
    parameter int STICKY  = 0,
    parameter int STAT_W  = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_AS_n,
    input  logic              i_A19,
    input  logic              i_CPUSP,
    input  logic              i_DTACK_n,
    input  logic              i_EN,
    input  logic              i_CLR,
    output logic              o_BERR_n,
    output logic              o_BERR,
    output logic              o_FAULT,
    output logic [STAT_W-1:0] o_FAULT_CNT,
    output logic [1:0]        o_dbg_state,
    output logic [CNT_W-1:0]  o_dbg_cnt
);

    generate
        if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
            $error("bus_watchdog: TIMEOUT must lie in 1..2**CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_BERR     = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [STAT_W-1:0] STAT_MAX  = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                berr_q, berr_d;
    logic                fault_q, fault_d;
    logic [STAT_W-1:0]   fault_cnt_q, fault_cnt_d;
    logic                active;
    logic                berr_entry;

    // A bus cycle is either a strobed CPU access or a CPU-space access decoded from A19.
    assign active = ~i_AS_n | (~i_CPUSP & i_A19);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            berr_q      <= 1'b0;
            fault_q     <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            berr_q      <= berr_d;
            fault_q     <= fault_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (active && i_EN) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (!active || !i_EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!i_DTACK_n) begin
                    state_d = ST_WAIT_END;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = ST_BERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BERR: begin
                if (STICKY == 0 && !active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_END: begin
                if (!active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A clear coinciding with a new timeout leaves exactly that one fault recorded.
    always_comb begin
        berr_d      = (state_d == ST_BERR);
        berr_entry  = (state_q != ST_BERR) && (state_d == ST_BERR);
        fault_d     = fault_q;
        fault_cnt_d = fault_cnt_q;
        if (i_CLR) begin
            fault_d     = berr_entry;
            fault_cnt_d = berr_entry ? STAT_W'(1) : '0;
        end else if (berr_entry) begin
            fault_d = 1'b1;
            if (fault_cnt_q != STAT_MAX) begin
                fault_cnt_d = fault_cnt_q + STAT_W'(1);
            end
        end
    end

    assign o_BERR      = berr_q;
    assign o_BERR_n    = berr_q ? 1'b0 : 1'bz;
    assign o_FAULT     = fault_q;
    assign o_FAULT_CNT = fault_cnt_q;
    assign o_dbg_state = state_q;
    assign o_dbg_cnt   = cnt_q;

endmodule

// File: doc/bus_watchdog.md
BUS_WATCHDOG -- requirements
Module: bus_watchdog

Interface
REQ-001 SHALL have parameter CNT_W, default 7, timeout counter width.
REQ-002 SHALL have parameter TIMEOUT, default 127, cycles counted before bus error; legal range 1..2^CNT_W-1; elaboration SHALL fail outside this range.
REQ-003 SHALL have parameter STICKY, default 0: 1 = bus error held until reset; 0 = bus error released at cycle end.
REQ-004 SHALL have parameter STAT_W, default 8, fault counter width.
REQ-005 SHALL have port i_CLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port i_RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_AS_n  input  1  CPU address strobe, active-low.
REQ-008 SHALL have port i_A19  input  1  address bit 19.
REQ-009 SHALL have port i_CPUSP  input  1  CPU space indicator; low with i_A19 high also qualifies.
REQ-010 SHALL have port i_DTACK_n  input  1  data acknowledge, active-low; normal termination.
REQ-011 SHALL have port i_EN  input  1  watchdog enable.
REQ-012 SHALL have port i_CLR  input  1  clears fault status.
REQ-013 SHALL have port o_BERR_n  output  1  open-drain bus error: 0 when asserted, else Z.
REQ-014 SHALL have port o_BERR  output  1  registered active-high bus error, internal use.
REQ-015 SHALL have port o_FAULT  output  1  sticky timeout-seen flag.
REQ-016 SHALL have port o_FAULT_CNT  output  STAT_W  saturating count of timeouts.

Function
REQ-017 active SHALL equal (~i_AS_n) OR (~i_CPUSP AND i_A19), evaluated combinationally.
REQ-018 FSM SHALL have states IDLE, COUNT, BERR, WAIT_END; counter SHALL be CNT_W bits.
REQ-019 IDLE: counter 0; active AND i_EN sampled -> COUNT with counter 1; else stay.
REQ-020 COUNT, priority order: ~active -> IDLE, counter 0; i_EN low -> IDLE; i_DTACK_n low -> WAIT_END; counter == TIMEOUT -> BERR; else counter+1.
REQ-021 o_BERR SHALL go high on the edge entering BERR, i.e. the (TIMEOUT+1)th consecutive edge sampling active, enabled, no DTACK.
REQ-022 i_DTACK_n low on the same edge that counter == TIMEOUT SHALL win: WAIT_END, no bus error.
REQ-023 Counter SHALL never wrap; it holds TIMEOUT at most.
REQ-024 BERR with STICKY=0: ~active sampled -> IDLE, o_BERR low same edge; i_EN and i_DTACK_n ignored.
REQ-025 BERR with STICKY=1: state and o_BERR held until i_RST.
REQ-026 WAIT_END: ~active -> IDLE; otherwise stay; i_EN ignored; no recount within same bus cycle.
REQ-027 o_BERR_n SHALL be 0 when o_BERR is 1, else high-impedance.
REQ-028 On entry to BERR, o_FAULT SHALL set and o_FAULT_CNT SHALL increment, saturating at 2^STAT_W-1.
REQ-029 i_CLR high SHALL zero o_FAULT and o_FAULT_CNT next edge; simultaneous BERR entry SHALL yield o_FAULT=1, o_FAULT_CNT=1.

Reset
REQ-030 i_RST high SHALL immediately (asynchronously) force IDLE, counter 0, o_BERR 0, o_BERR_n Z, o_FAULT 0, o_FAULT_CNT 0.
REQ-031 Reset asserted in BERR, either STICKY value, SHALL release o_BERR_n without a clock edge.
REQ-032 After i_RST deasserts, first edge SHALL behave as IDLE per REQ-019.

Verification
REQ-033 Defaults, i_EN=1, i_AS_n low, DTACK high 200 cycles -> o_BERR_n low on edge 128; high-Z after i_AS_n rises, next edge; o_FAULT=1, o_FAULT_CNT=1.
REQ-034 i_AS_n low, i_DTACK_n low at edge 50 -> no bus error; i_AS_n held low 300 more cycles stays WAIT_END, o_BERR_n Z.
REQ-035 i_DTACK_n low exactly at edge 128 -> no bus error (REQ-022); edge 127 DTACK high, counter 127.
REQ-036 STICKY=1, TIMEOUT=3 -> o_BERR_n low on edge 4, remains low after i_AS_n rises, released only by i_RST.
REQ-037 STAT_W=2, four timeouts -> o_FAULT_CNT 1,2,3,3; i_CLR coincident with fifth timeout -> o_FAULT=1, o_FAULT_CNT=1.
REQ-038 i_EN low, i_CPUSP low, i_A19 high indefinitely -> no bus error; i_EN raised -> bus error 128 edges later; i_RST mid-count -> counter 0, restart full 128.
